// File: rtl/cla_sub_pipe_44bit_pkg.sv
// Shared constants and the stage-register layout for the pipelined 44-bit CLA subtractor.
// Optional signed-overflow output is selected with CLA_SUB_SIGNED_OVF_EN.
package cla_pkg;

    localparam int CLA_WIDTH  = 44;
    localparam int CLA_SEG_W  = 11;
    localparam int CLA_STAGES = CLA_WIDTH / CLA_SEG_W;

    // Operands travel whole; each stage consumes its own segment of them and
    // fills in the matching slice of diff_lo.
    typedef struct packed {
        logic                 valid;
        logic [CLA_WIDTH-1:0] min_hi;
        logic [CLA_WIDTH-1:0] sub_hi;
        logic [CLA_WIDTH-1:0] diff_lo;
        logic                 borrow;
    } cla_stage_t;

endpackage

// File: rtl/cla_sub_pipe_44bit_if.sv
// Operand/result handshake bundle for cla_sub_pipe_44bit.
// o_ovf exists only when CLA_SUB_SIGNED_OVF_EN is defined.
interface cla_sub_pipe_44bit_if;
    import cla_pkg::*;

    logic                 i_valid;
    logic                 o_ready;
    logic [CLA_WIDTH-1:0] i_min;
    logic [CLA_WIDTH-1:0] i_sub;
    logic                 o_valid;
    logic                 i_ready;
    logic [CLA_WIDTH:0]   o_result;
`ifdef CLA_SUB_SIGNED_OVF_EN
    logic                 o_ovf;

    modport master (
        output i_valid, i_min, i_sub, i_ready,
        input  o_ready, o_valid, o_result, o_ovf
    );
    modport slave (
        input  i_valid, i_min, i_sub, i_ready,
        output o_ready, o_valid, o_result, o_ovf
    );
`else
    modport master (
        output i_valid, i_min, i_sub, i_ready,
        input  o_ready, o_valid, o_result
    );
    modport slave (
        input  i_valid, i_min, i_sub, i_ready,
        output o_ready, o_valid, o_result
    );
`endif

endinterface

// File: rtl/cla_sub_pipe_44bit_segment.sv
// Combinational SEG_W-bit borrow-lookahead slice: every internal borrow is a
// flat sum of generate/propagate products rather than a ripple chain.
module cla_sub_segment #(
    parameter int SEG_W = 11
) (
    input  logic [SEG_W-1:0] a_i,
    input  logic [SEG_W-1:0] b_i,
    input  logic             bin_i,
    output logic [SEG_W-1:0] d_o,
    output logic             bout_o
);

    logic [SEG_W-1:0] g;
    logic [SEG_W-1:0] p;
    logic [SEG_W:0]   bw;
    logic             term;

    assign g = ~a_i & b_i;
    assign p = ~(a_i ^ b_i);

    // bw[i] = bin&p[0..i-1]  |  OR_j g[j]&p[j+1..i-1]
    always_comb begin
        bw   = '0;
        term = 1'b0;
        for (int i = 0; i <= SEG_W; i++) begin
            term = bin_i;
            for (int j = 0; j < i; j++) begin
                term = term & p[j];
            end
            bw[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                bw[i] = bw[i] | term;
            end
        end
    end

    assign d_o    = a_i ^ b_i ^ bw[SEG_W-1:0];
    assign bout_o = bw[SEG_W];

endmodule

// File: rtl/cla_sub_pipe_44bit.sv
// Pipelined carry-lookahead subtractor: one SEG_W-bit segment per stage, global stall.
// Define CLA_SUB_SIGNED_OVF_EN to add the two's-complement overflow output o_ovf.
module cla_sub_pipe_44bit
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int SEG_W = CLA_SEG_W
) (
    input logic                 i_clk,
    input logic                 i_rst,
    cla_sub_pipe_44bit_if.slave bus
);

    localparam int STAGES = WIDTH / SEG_W;

    if (WIDTH % SEG_W != 0) begin : g_bad_seg
        $fatal(1, "cla_sub_pipe_44bit: WIDTH must be a multiple of SEG_W");
    end
    if (WIDTH != CLA_WIDTH) begin : g_bad_width
        $fatal(1, "cla_sub_pipe_44bit: WIDTH must match cla_pkg::CLA_WIDTH");
    end

    cla_stage_t pipe_q [STAGES];
    cla_stage_t pipe_d [STAGES];
    cla_stage_t in_st;
    cla_stage_t last;
    logic       advance;

    assign last    = pipe_q[STAGES-1];
    assign advance = !last.valid | bus.i_ready;

    always_comb begin
        in_st         = '0;
        in_st.valid   = bus.i_valid;
        in_st.min_hi  = bus.i_min;
        in_st.sub_hi  = bus.i_sub;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        cla_stage_t       cur;
        cla_stage_t       nxt;
        logic [SEG_W-1:0] seg_d;
        logic             seg_bout;

        if (k == 0) begin : g_first
            assign cur = in_st;
        end else begin : g_next
            assign cur = pipe_q[k-1];
        end

        cla_sub_segment #(.SEG_W(SEG_W)) u_seg (
            .a_i    (cur.min_hi[k*SEG_W +: SEG_W]),
            .b_i    (cur.sub_hi[k*SEG_W +: SEG_W]),
            .bin_i  (cur.borrow),
            .d_o    (seg_d),
            .bout_o (seg_bout)
        );

        always_comb begin
            nxt                            = cur;
            nxt.diff_lo[k*SEG_W +: SEG_W]  = seg_d;
            nxt.borrow                     = seg_bout;
        end

        assign pipe_d[k] = nxt;
    end

    // Stage boundary: all stages move together or all hold.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= '0;
            end
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign bus.o_ready  = advance;
    assign bus.o_valid  = last.valid;
    assign bus.o_result = {last.borrow, last.diff_lo};

`ifdef CLA_SUB_SIGNED_OVF_EN
    assign bus.o_ovf = (last.min_hi[WIDTH-1] != last.sub_hi[WIDTH-1]) &
                       (last.diff_lo[WIDTH-1] != last.min_hi[WIDTH-1]);
`endif

endmodule

// File: tb/tb_cla_sub_pipe_44bit.sv
// Bench for cla_sub_pipe_44bit: directed and random operands scored against an
// arithmetic reference queue, plus latency, stall, reset and overflow checks.
module tb_cla_sub_pipe_44bit;
    import cla_pkg::*;

    localparam int W = CLA_WIDTH;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cla_sub_pipe_44bit_if bus ();

    cla_sub_pipe_44bit dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [W:0] res;
        logic       ovf;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         last_lat    = 0;
    int         pops        = 0;
    logic [W:0] last_res    = '0;
    logic       last_ovf    = 1'b0;
    logic       stall_prev  = 1'b0;
    logic [W:0] stall_res   = '0;

    // Reference: plain (W+1)-bit unsigned subtraction and a signed range test.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa;
        longint sbv;
        longint sd;
        e.res = {1'b0, a} - {1'b0, b};
        sa    = $signed(a);
        sbv   = $signed(b);
        sd    = sa - sbv;
        e.ovf = (sd > 64'sd8796093022207) || (sd < -64'sd8796093022208);
        e.cyc = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd44();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 9))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            default: return r[W-1:0];
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic rdy);
        bus.i_valid = v;
        bus.i_min   = a;
        bus.i_sub   = b;
        bus.i_ready = rdy;
    endtask

    // One clock: score handshakes at the negedge, then step past the posedge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 64'(bus.o_valid), 64'd1);
                chk("stall_result", 64'(bus.o_result), 64'(stall_res));
            end
            if (bus.o_valid && bus.i_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(bus.o_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 64'(bus.o_result), 64'(e.res));
`ifdef CLA_SUB_SIGNED_OVF_EN
                    chk("ovf", 64'(bus.o_ovf), 64'(e.ovf));
                    last_ovf = bus.o_ovf;
`endif
                    last_res = bus.o_result;
                    last_lat = cyc - e.cyc;
                    pops++;
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                e     = model(bus.i_min, bus.i_sub);
                e.cyc = cyc;
                sb.push_back(e);
            end
            stall_prev = bus.o_valid && !bus.i_ready;
            stall_res  = bus.o_result;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        drive(1'b0, '0, '0, 1'b1);
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        repeat (2) cycle();
        rst = 1'b0;
        chk("rst_valid", 64'(bus.o_valid), 64'd0);
        chk("rst_ready", 64'(bus.o_ready), 64'd1);
        chk("rst_result", 64'(bus.o_result), 64'd0);

        // 1000 - 1 with exact latency
        drive(1'b1, 44'd1000, 44'd1, 1'b1);
        cycle();
        drain(20);
        chk("lat_4", 64'(last_lat), 64'd4);
        chk("t1_res", 64'(last_res), 64'({1'b0, 44'd999}));

        // 0 - 1: borrow through every segment
        drive(1'b1, 44'd0, 44'd1, 1'b1);
        cycle();
        drain(20);
        chk("t2_res", 64'(last_res), 64'({1'b1, 44'hFFF_FFFF_FFFF}));

        // 100 back-to-back random pairs
        pops = 0;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, rnd44(), rnd44(), 1'b1);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1);
        repeat (4) cycle();
        chk("stream_count", 64'(pops), 64'd100);
        chk("stream_empty", 64'(sb.size()), 64'd0);

        // Fill, then hold i_ready low for 6 cycles while offering more data
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, rnd44(), rnd44(), 1'b1);
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, rnd44(), rnd44(), 1'b0);
            cycle();
            chk("stall_ready", 64'(bus.o_ready), 64'd0);
        end
        chk("stall_inflight", 64'(sb.size()), 64'd4);
        drain(20);

        // Random valid/ready traffic
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 1)), rnd44(), rnd44(), 1'($urandom_range(0, 3) != 0));
            cycle();
        end
        drain(60);

        // Reset with three operands in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rnd44(), rnd44(), 1'b1);
            cycle();
        end
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        cycle();
        rst = 1'b0;
        chk("midrst_valid", 64'(bus.o_valid), 64'd0);
        chk("midrst_result", 64'(bus.o_result), 64'd0);
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, rnd44(), rnd44(), 1'b1);
            cycle();
        end
        drain(20);
        chk("post_rst_count", 64'(pops), 64'd5);

        // Signed-overflow corners
        drive(1'b1, 44'h7FF_FFFF_FFFF, 44'hFFF_FFFF_FFFF, 1'b1);
        cycle();
        drain(20);
        chk("ovf_case_res", 64'(last_res), 64'({1'b1, 44'h800_0000_0000}));
`ifdef CLA_SUB_SIGNED_OVF_EN
        chk("ovf_case_flag", 64'(last_ovf), 64'd1);
`endif
        drive(1'b1, 44'd5, 44'd3, 1'b1);
        cycle();
        drain(20);
        chk("noovf_res", 64'(last_res), 64'd2);
`ifdef CLA_SUB_SIGNED_OVF_EN
        chk("noovf_flag", 64'(last_ovf), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
